// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, flags illegal opcodes and counts retired instructions.
module mc_control #(
    parameter int unsigned ALUCTL_W = 5,
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          Funct,
    input  logic                zero,
    input  logic                gtz,
    input  logic                mem_ready,
    output logic [ALUCTL_W-1:0] ALUcontrol,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic [1:0]          PCSource,
    output logic                PCWrite,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBgtz  = 6'h07;
    localparam logic [5:0] OpJ     = 6'h02;

    localparam logic [2:0] AluPass = 3'd0;
    localparam logic [2:0] AluAdd  = 3'd1;
    localparam logic [2:0] AluSub  = 3'd2;
    localparam logic [2:0] AluAnd  = 3'd3;
    localparam logic [2:0] AluOr   = 3'd4;
    localparam logic [2:0] AluSlt  = 3'd5;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               mem_done;
    logic               funct_ok;
    logic [2:0]         funct_alu;
    logic [2:0]         alu_code;
    logic               retire;
    logic               mem_read_c, mem_write_c, ir_write_c, reg_write_c, pc_write_c;
    logic               illegal_c;

    assign mem_done = (MEM_WAIT == 0) || mem_ready;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = AluAdd;
        case (Funct)
            6'h20:   funct_alu = AluAdd;
            6'h22:   funct_alu = AluSub;
            6'h24:   funct_alu = AluAnd;
            6'h25:   funct_alu = AluOr;
            6'h2A:   funct_alu = AluSlt;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        alu_code    = AluPass;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        IorD        = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'd0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        pc_write_c  = 1'b0;
        illegal_c   = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read_c = 1'b1;
                ALUSrcB    = 2'd1;
                alu_code   = AluAdd;
                if (mem_done) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                ALUSrcB  = 2'd3;
                alu_code = AluAdd;
                if (op == OpLw || op == OpSw) begin
                    state_d = StMemAdr;
                end else if ((op == OpRtype && funct_ok) || op == OpAddi) begin
                    state_d = StExec;
                end else if (op == OpBeq || op == OpBgtz) begin
                    state_d = StBranch;
                end else if (op == OpJ) begin
                    state_d = StJump;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = StFetch;
                end
            end
            StMemAdr: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'd2;
                alu_code = AluAdd;
                state_d  = (op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read_c = 1'b1;
                IorD       = 1'b1;
                if (mem_done) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write_c = 1'b1;
                MemtoReg    = 1'b1;
                retire      = 1'b1;
                state_d     = StFetch;
            end
            StMemWr: begin
                mem_write_c = 1'b1;
                IorD        = 1'b1;
                if (mem_done) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExec: begin
                ALUSrcA = 1'b1;
                if (op == OpRtype) begin
                    ALUSrcB  = 2'd0;
                    alu_code = funct_alu;
                end else begin
                    ALUSrcB  = 2'd2;
                    alu_code = AluAdd;
                end
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_write_c = 1'b1;
                RegDst      = (op == OpRtype);
                retire      = 1'b1;
                state_d     = StFetch;
            end
            StBranch: begin
                ALUSrcA  = 1'b1;
                PCSource = 2'd1;
                if (op == OpBeq) begin
                    alu_code   = AluSub;
                    pc_write_c = zero;
                end else begin
                    alu_code   = AluPass;
                    pc_write_c = gtz;
                end
                retire  = 1'b1;
                state_d = StFetch;
            end
            StJump: begin
                PCSource   = 2'd2;
                pc_write_c = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    assign count_d = retire ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Reset lands the FSM in FETCH immediately, so strobes must be masked while it is held.
    assign MemRead     = mem_read_c & ~rst;
    assign MemWrite    = mem_write_c & ~rst;
    assign IRWrite     = ir_write_c & ~rst;
    assign RegWrite    = reg_write_c & ~rst;
    assign PCWrite     = pc_write_c & ~rst;
    assign illegal     = illegal_c & ~rst;
    assign ALUcontrol  = ALUCTL_W'(alu_code);
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus randomized instruction stream
// checked against a per-instruction trace model built from the instruction-class rules.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst, rst2;
    logic [5:0] op, funct, op2;
    logic       zero, gtz, mem_ready, mem_ready2;

    logic [4:0]  alu_ctl, alu_ctl2;
    logic        src_a, src_a2, iord, iord2, mem_rd, mem_rd2, mem_wr, mem_wr2;
    logic        ir_wr, ir_wr2, m2r, m2r2, reg_dst, reg_dst2, reg_wr, reg_wr2;
    logic        pc_wr, pc_wr2, ill, ill2;
    logic [1:0]  src_b, src_b2, pc_src, pc_src2;
    logic [3:0]  st, st2;
    logic [31:0] cnt;
    logic [3:0]  cnt2;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .rst(rst), .op(op), .Funct(funct), .zero(zero), .gtz(gtz),
        .mem_ready(mem_ready), .ALUcontrol(alu_ctl), .ALUSrcA(src_a), .ALUSrcB(src_b),
        .IorD(iord), .MemRead(mem_rd), .MemWrite(mem_wr), .IRWrite(ir_wr), .MemtoReg(m2r),
        .RegDst(reg_dst), .RegWrite(reg_wr), .PCSource(pc_src), .PCWrite(pc_wr),
        .illegal(ill), .state(st), .instr_count(cnt)
    );

    mc_control #(.ALUCTL_W(5), .MEM_WAIT(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst2), .op(op2), .Funct(funct), .zero(zero), .gtz(gtz),
        .mem_ready(mem_ready2), .ALUcontrol(alu_ctl2), .ALUSrcA(src_a2), .ALUSrcB(src_b2),
        .IorD(iord2), .MemRead(mem_rd2), .MemWrite(mem_wr2), .IRWrite(ir_wr2),
        .MemtoReg(m2r2), .RegDst(reg_dst2), .RegWrite(reg_wr2), .PCSource(pc_src2),
        .PCWrite(pc_wr2), .illegal(ill2), .state(st2), .instr_count(cnt2)
    );

    // One expected cycle; -1 in an int field means "not checked".
    typedef struct {
        int st; bit rdy; bit mr; bit mw; bit irw; bit rw; bit pcw; bit ill;
        int alu; int rd; int m2r; int pcs;
    } ent_t;

    ent_t exp_q[$];

    function automatic ent_t mk(int s, bit rdy, bit mr, bit mw, bit irw, bit rw, bit pcw,
                                bit il, int alu, int rd, int mtr, int pcs);
        ent_t e;
        e.st = s; e.rdy = rdy; e.mr = mr; e.mw = mw; e.irw = irw; e.rw = rw; e.pcw = pcw;
        e.ill = il; e.alu = alu; e.rd = rd; e.m2r = mtr; e.pcs = pcs;
        return e;
    endfunction

    function automatic int r_alu(logic [5:0] f);
        case (f)
            6'h20: return 1;
            6'h22: return 2;
            6'h24: return 3;
            6'h25: return 4;
            6'h2A: return 5;
            default: return -1;
        endcase
    endfunction

    // Build the expected trace of one instruction, then drive and check it cycle by cycle.
    task automatic run_instr(logic [5:0] o, logic [5:0] f, bit z, bit g, int wf, int wm);
        bit legal;
        int cyc;
        exp_q.delete();
        for (int i = 0; i < wf; i++) exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, -1, -1, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, 1, -1, -1, 0));
        legal = (o == 6'h23) || (o == 6'h2B) || (o == 6'h08) || (o == 6'h04) || (o == 6'h07) ||
                (o == 6'h02) || (o == 6'h00 && r_alu(f) >= 0);
        exp_q.push_back(mk(1, 1'($urandom), 0, 0, 0, 0, 0, !legal, 1, -1, -1, -1));
        if (legal) begin
            case (o)
                6'h23: begin
                    exp_q.push_back(mk(2, 1'($urandom), 0, 0, 0, 0, 0, 0, 1, -1, -1, -1));
                    for (int i = 0; i < wm; i++)
                        exp_q.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, -1, -1, -1, -1));
                    exp_q.push_back(mk(3, 1, 1, 0, 0, 0, 0, 0, -1, -1, -1, -1));
                    exp_q.push_back(mk(4, 1'($urandom), 0, 0, 0, 1, 0, 0, -1, 0, 1, -1));
                end
                6'h2B: begin
                    exp_q.push_back(mk(2, 1'($urandom), 0, 0, 0, 0, 0, 0, 1, -1, -1, -1));
                    for (int i = 0; i < wm; i++)
                        exp_q.push_back(mk(5, 0, 0, 1, 0, 0, 0, 0, -1, -1, -1, -1));
                    exp_q.push_back(mk(5, 1, 0, 1, 0, 0, 0, 0, -1, -1, -1, -1));
                end
                6'h00: begin
                    exp_q.push_back(mk(6, 1'($urandom), 0, 0, 0, 0, 0, 0, r_alu(f), -1, -1, -1));
                    exp_q.push_back(mk(7, 1'($urandom), 0, 0, 0, 1, 0, 0, -1, 1, 0, -1));
                end
                6'h08: begin
                    exp_q.push_back(mk(6, 1'($urandom), 0, 0, 0, 0, 0, 0, 1, -1, -1, -1));
                    exp_q.push_back(mk(7, 1'($urandom), 0, 0, 0, 1, 0, 0, -1, 0, 0, -1));
                end
                6'h04: exp_q.push_back(mk(8, 1'($urandom), 0, 0, 0, 0, z, 0, 2, -1, -1, 1));
                6'h07: exp_q.push_back(mk(8, 1'($urandom), 0, 0, 0, 0, g, 0, 0, -1, -1, 1));
                default: exp_q.push_back(mk(9, 1'($urandom), 0, 0, 0, 0, 1, 0, -1, -1, -1, 2));
            endcase
        end
        cyc = 0;
        foreach (exp_q[k]) begin
            @(negedge clk);
            op = o; funct = f; zero = z; gtz = g; mem_ready = exp_q[k].rdy;
            #1;
            if (k == 0) begin
                checks++;
                if (cnt !== 32'(exp_cnt)) begin
                    failures++;
                    $display("FAIL instr_count op=%h got=%0d exp=%0d", o, cnt, exp_cnt);
                end
            end
            checks++;
            if (st !== 4'(exp_q[k].st) || mem_rd !== exp_q[k].mr || mem_wr !== exp_q[k].mw ||
                ir_wr !== exp_q[k].irw || reg_wr !== exp_q[k].rw || pc_wr !== exp_q[k].pcw ||
                ill !== exp_q[k].ill) begin
                failures++;
                $display("FAIL trace op=%h f=%h cyc=%0d got st=%0d mr/mw/irw/rw/pcw/ill=%b%b%b%b%b%b exp st=%0d %b%b%b%b%b%b",
                         o, f, cyc, st, mem_rd, mem_wr, ir_wr, reg_wr, pc_wr, ill,
                         exp_q[k].st, exp_q[k].mr, exp_q[k].mw, exp_q[k].irw, exp_q[k].rw,
                         exp_q[k].pcw, exp_q[k].ill);
            end
            if (exp_q[k].alu >= 0) begin
                checks++;
                if (alu_ctl !== 5'(exp_q[k].alu)) begin
                    failures++;
                    $display("FAIL alu op=%h cyc=%0d got=%0d exp=%0d", o, cyc, alu_ctl, exp_q[k].alu);
                end
            end
            if (exp_q[k].rd >= 0) begin
                checks++;
                if (reg_dst !== 1'(exp_q[k].rd) || m2r !== 1'(exp_q[k].m2r)) begin
                    failures++;
                    $display("FAIL wb_sel op=%h got RegDst=%b MemtoReg=%b exp %0d %0d",
                             o, reg_dst, m2r, exp_q[k].rd, exp_q[k].m2r);
                end
            end
            if (exp_q[k].pcs >= 0) begin
                checks++;
                if (pc_src !== 2'(exp_q[k].pcs)) begin
                    failures++;
                    $display("FAIL pcsource op=%h cyc=%0d got=%0d exp=%0d", o, cyc, pc_src, exp_q[k].pcs);
                end
            end
            cyc++;
        end
        if (legal) exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; mem_ready = 1'b1; mem_ready2 = 1'b0;
        op = 6'h00; op2 = 6'h02; funct = 6'h20; zero = 1'b0; gtz = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (st !== 4'd0 || cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got st=%0d cnt=%0d exp 0 0", st, cnt);
        end
        checks++;
        if (mem_rd !== 1'b0 || ir_wr !== 1'b0 || pc_wr !== 1'b0 || ill !== 1'b0) begin
            failures++;
            $display("FAIL reset_enables got mr=%b irw=%b pcw=%b ill=%b exp 0", mem_rd, ir_wr, pc_wr, ill);
        end
        @(negedge clk);
        mem_ready = 1'b0; rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_rtype_add();
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_lw_wait();
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 3);
        run_instr(6'h2B, 6'h11, 1'b0, 1'b0, 2, 1);
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, 0, 0);
        run_instr(6'h07, 6'h00, 1'b0, 1'b1, 1, 0);
        run_instr(6'h07, 6'h00, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h20, 1'b0, 1'b0, 0, 0);
        run_instr(6'h00, 6'h08, 1'b0, 1'b0, 0, 0);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        ops = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h07, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        for (int i = 0; i < 60; i++) begin
            logic [5:0] o, f;
            o = ops[$urandom_range(0, 7)];
            if (o == 6'h3F) o = 6'($urandom_range(0, 63));
            f = fns[$urandom_range(0, 5)];
            if (f == 6'h00) f = 6'($urandom_range(0, 63));
            run_instr(o, f, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk); op = 6'h2B; mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (st !== 4'd5 || mem_wr !== 1'b1) begin
            failures++;
            $display("FAIL memwr_wait got st=%0d mw=%b exp 5 1", st, mem_wr);
        end
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (st !== 4'd0 || mem_wr !== 1'b0 || cnt !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got st=%0d mw=%b cnt=%0d exp 0 0 0", st, mem_wr, cnt);
        end
        @(negedge clk);
        mem_ready = 1'b0; rst = 1'b0;
        exp_cnt = 0;
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, 1, 0);
        run_instr(6'h08, 6'h00, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_count_wrap();
        int n;
        n = 0;
        @(negedge clk); rst2 = 1'b0; op2 = 6'h02; mem_ready2 = 1'b0;
        for (int j = 0; j < 17; j++) begin
            for (int c = 0; c < 3; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                checks++;
                if (st2 !== 4'(c == 2 ? 9 : c) || (c == 2 && pc_wr2 !== 1'b1)) begin
                    failures++;
                    $display("FAIL wrap_trace jump=%0d got st=%0d pcw=%b exp st=%0d", j, st2, pc_wr2,
                             (c == 2 ? 9 : c));
                end
            end
            @(negedge clk);
            n++;
            checks++;
            if (cnt2 !== 4'(n % 16)) begin
                failures++;
                $display("FAIL wrap_count jump=%0d got=%0d exp=%0d", j, cnt2, n % 16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_random();
        test_reset_mid_access();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle main decoder. A registered FSM sequences each MIPS instruction through fetch, decode, execute, memory and writeback.
- Drives datapath mux selects, write enables and ALU control per state.
- Adds a memory-ready wait handshake, beq alongside bgtz, R-type funct decode, illegal-instruction flagging, and a retired-instruction counter.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
- ALUCTL_W, 5, width of ALUcontrol (min 3; codes zero-extended).
- MEM_WAIT, 1, 1 = memory states hold until mem_ready; 0 = memory states last exactly one cycle and mem_ready is ignored.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  opcode from IR; stable from DECODE until next FETCH.
- Funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0.
- gtz  in  1  rs > 0 (signed), from datapath comparator.
- mem_ready  in  1  memory access complete this cycle.
- ALUcontrol  out  ALUCTL_W  ALU op code.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load instruction register.
- MemtoReg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- PCSource  out  2  0 = ALU, 1 = ALUOut, 2 = jump target.
- PCWrite  out  1  final PC enable (unconditional OR qualified branch).
- illegal  out  1  one-cycle pulse on unsupported op/Funct.
- state  out  4  current state, for debug.
- instr_count  out  CNT_W  retired instructions; wraps.

Behaviour:
- Reset:
  - Async rst → state = FETCH (0), instr_count = 0.
  - While rst is high, all enables (MemRead, MemWrite, IRWrite, RegWrite, PCWrite) and illegal are forced 0.
  - All outputs not listed in a state are 0.
  - ALU codes: add = 1, sub = 2, and = 3, or = 4, slt = 5, pass = 0.
- FETCH (0): MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ALUcontrol = add, PCSource = 0.
  - IRWrite = 1 and PCWrite = 1 only in the cycle where the access completes.
  - Access completes when MEM_WAIT = 0, or mem_ready = 1.
  - On completion → DECODE; otherwise stay.
- DECODE (1): ALUSrcA = 0, ALUSrcB = 3, ALUcontrol = add (branch target into ALUOut). Next state by op:
  - 0x23 / 0x2B → MEMADR.
  - 0x00 with Funct in {0x20, 0x22, 0x24, 0x25, 0x2A} → EXEC.
  - 0x08 → EXEC.
  - 0x04 / 0x07 → BRANCH.
  - 0x02 → JUMP.
  - Anything else → FETCH, with illegal = 1 for this cycle; instr_count is not incremented.
- MEMADR (2): ALUSrcA = 1, ALUSrcB = 2, add. → MEMRD if lw, MEMWR if sw.
- MEMRD (3): MemRead = 1, IorD = 1. Wait rule as in FETCH; on completion → MEMWB.
- MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0. → FETCH, instr_count++.
- MEMWR (5): MemWrite = 1, IorD = 1, held for the whole wait. On completion → FETCH, instr_count++.
- EXEC (6): ALUSrcA = 1.
  - R-type: ALUSrcB = 0, ALUcontrol from Funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt).
  - addi: ALUSrcB = 2, add.
  - → ALUWB.
- ALUWB (7): RegWrite = 1, MemtoReg = 0, RegDst = 1 for R-type, 0 for addi. → FETCH, instr_count++.
- BRANCH (8): ALUSrcA = 1, ALUSrcB = 0, PCSource = 1.
  - beq: ALUcontrol = sub; PCWrite = zero.
  - bgtz: ALUcontrol = pass; PCWrite = gtz.
  - → FETCH, instr_count++.
- JUMP (9): PCSource = 2, PCWrite = 1. → FETCH, instr_count++.
- General rules:
  - Outputs are Moore (decoded from registered state), except PCWrite in BRANCH and the completion-gated IRWrite/PCWrite in FETCH.
  - Unused state encodes (10–15) → FETCH next cycle, with all enables 0.
  - instr_count wraps from all-ones to 0 with no flag.
  - Reset asserted mid-access: immediate return to FETCH; any outstanding mem_ready is ignored.

Test Plan:
- Reset, then op = 0x00, Funct = 0x20, mem_ready tied 1 → states 0, 1, 6, 7, 0; RegWrite = 1 and RegDst = 1 only in state 7; instr_count = 1.
- MEM_WAIT = 1, lw (op = 0x23) with mem_ready low for 3 cycles in MEMRD → state holds at 3 for 3 cycles; MemRead = 1 throughout; MEMWB writes with MemtoReg = 1; total 8 cycles including fetch.
- beq with zero = 1 → PCWrite = 1, PCSource = 1 in state 8; repeat with zero = 0 → PCWrite = 0. bgtz with gtz = 1 → PCWrite = 1, ALUcontrol = 0.
- op = 0x3F, then op = 0x00 with Funct = 0x08 → illegal = 1 for one cycle in DECODE; next state 0; instr_count unchanged.
- rst asserted in MEMWR mid-wait → state = 0 asynchronously; MemWrite drops same cycle; instr_count = 0.
- CNT_W = 4, execute 17 jumps → instr_count = 1 after the wrap.
